// File: rtl/division_iter.sv
// division_iter: parametrised restoring divider, one quotient bit per clock.
// Signed or unsigned per request, divide-by-zero flagged, fixed latency of
// WIDTH+2 cycles per result with a start/busy/done handshake.
module division_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic             sm_r;        // signed mode captured with start
    logic             neg_dvd;     // dividend was negative (signed mode only)
    logic             neg_dvs;     // divisor was negative (signed mode only)
    logic             zero_dvs;    // divisor was zero
    logic [WIDTH-1:0] dvd_raw;     // original dividend, returned on divide-by-zero
    logic [WIDTH-1:0] dvs_mag;     // divisor magnitude
    logic [WIDTH-1:0] quo;         // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   rem;         // partial remainder
    logic [CW-1:0]    cnt;         // iterations left

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // Two's-complement negation; the most-negative value maps onto its
    // own bit pattern, which read unsigned is exactly 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] x,
                                                     input logic en);
        return en ? negate(x) : x;
    endfunction

    // Shift in the next dividend bit and trial-subtract the divisor magnitude;
    // the extra top bit of trial is the borrow (negative result).
    always_comb begin
        shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dvs_mag};
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            sm_r        <= 1'b0;
            neg_dvd     <= 1'b0;
            neg_dvs     <= 1'b0;
            zero_dvs    <= 1'b0;
            dvd_raw     <= '0;
            dvs_mag     <= '0;
            quo         <= '0;
            rem         <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sm_r     <= signed_mode;
                        neg_dvd  <= signed_mode & dividend[WIDTH-1];
                        neg_dvs  <= signed_mode & divisor[WIDTH-1];
                        zero_dvs <= (divisor == '0);
                        dvd_raw  <= dividend;
                        quo      <= cond_negate(dividend, signed_mode & dividend[WIDTH-1]);
                        dvs_mag  <= cond_negate(divisor, signed_mode & divisor[WIDTH-1]);
                        rem      <= '0;
                        cnt      <= CW'(WIDTH);
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // Borrow set: restore (keep shifted value), quotient bit 0.
                    rem <= trial[WIDTH+1] ? shifted : trial[WIDTH:0];
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zero_dvs) begin
                        quotient    <= '1;
                        remainder   <= dvd_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        // Truncating division: remainder follows the dividend sign.
                        quotient    <= cond_negate(quo, sm_r & (neg_dvd ^ neg_dvs));
                        remainder   <= cond_negate(rem[WIDTH-1:0], sm_r & neg_dvd);
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/division_iter.md
# division_iter

Parametrised multi-cycle integer divider, the next-generation successor to the fixed-width 4-bit divider. It computes quotient and remainder one bit per clock with a restoring algorithm, and its width is set by a parameter. It selects signed or unsigned operation per request and flags divide-by-zero. It exposes a start/busy/done handshake so a controller or a datapath ALU can issue back-to-back divisions.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width in bits. The legal range is 2 to 32.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `start`  in  1: request a division. It is sampled only in IDLE.
- `signed_mode`  in  1: 1 selects two's-complement operands, 0 selects unsigned. It is sampled with `start`.
- `dividend`  in  WIDTH: dividend, sampled with `start`.
- `divisor`  in  WIDTH: divisor, sampled with `start`.
- `busy`  out  1: high while a division is in progress (state is not IDLE).
- `done`  out  1: one-cycle pulse; results are valid from this cycle onward.
- `div_by_zero`  out  1: set with `done` when the divisor was 0; it holds until the next `done`.
- `quotient`  out  WIDTH: result quotient, held until the next `done`.
- `remainder`  out  WIDTH: result remainder, held until the next `done`.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE → CALC, on `start`=1:**
  - Latch `signed_mode`, the sign of the dividend, the sign of the divisor, and a zero-divisor flag.
  - Latch the magnitudes |dividend| and |divisor|. In unsigned mode these are the raw values. In signed mode a negative operand is negated, and the most-negative value maps to its unsigned magnitude 2^(WIDTH-1).
  - Clear the partial remainder (WIDTH+1 bits) and load the iteration counter with WIDTH.
- **CALC, one iteration per cycle for exactly WIDTH cycles:**
  - Shift {partial remainder, quotient register} left by one, bringing in the next dividend bit from the MSB.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set the quotient LSB to 1. Otherwise restore the remainder and set the LSB to 0.
  - Decrement the counter; when it reaches 0, go to FIX.
- **FIX, one cycle, then → IDLE:**
  - Apply signs in signed mode. The quotient is negated if the operand signs differ. The remainder takes the sign of the dividend (truncating division).
  - Register `quotient`, `remainder` and `div_by_zero`, and pulse `done`.
- **Divide by zero:** the iteration still runs for constant latency. In FIX the outputs are forced to `quotient` = all ones, `remainder` = original dividend, `div_by_zero` = 1. This applies in both modes.
- **Signed overflow (MIN / -1):** no special case. The natural result is `quotient` = MIN, `remainder` = 0, `div_by_zero` = 0.
- **`start` while busy:** ignored. Operands are not re-sampled and there is no error indication.
- **Operand changes after the capture edge:** no effect on the current result.

## Timing
- **Reset** (`rst_n`=0 at a rising edge):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `div_by_zero`=0, `quotient`=0, `remainder`=0. Internal registers are cleared.
- **Reset mid-operation:** the division is aborted, no `done` pulse is produced, and the outputs take their reset values.
- **Latency:** with the capture edge as E0, the iterations occur on E1..E{WIDTH}. FIX updates the outputs and raises `done` on E{WIDTH+1}. `done` is high for exactly the cycle following E{WIDTH+1}.
- **`busy`:** goes high after E0 and low after E{WIDTH+1}, so it falls in the same cycle that `done` rises.
- **Back-to-back requests:** `start`=1 during the `done` cycle is accepted (the state is IDLE). The new division's `done` arrives WIDTH+2 cycles after the previous one. The throughput is one result per WIDTH+2 cycles.
- **Output stability:** outputs change only on a FIX edge or on reset. `done`=0 never alters held results.

## Test plan
- **Unsigned, WIDTH=4:** `start` with 8/4, then 8/3, then 8/5.
  - Required results: q=2 r=0; q=2 r=2; q=1 r=3.
  - `done` is high exactly 5 edges after the capture edge, and `busy` is high for 5 cycles.
- **Signed, WIDTH=8:**
  - -7/2 → q=8'hFD r=8'hFF.
  - 7/-2 → q=8'hFD r=8'h01.
  - -7/-2 → q=8'h03 r=8'hFF.
  - 200/7 with `signed_mode`=0 → q=28 r=4.
- **Divide by zero:**
  - WIDTH=4 unsigned 13/0 → q=4'hF, r=4'hD, `div_by_zero`=1.
  - The next 6/2 → q=3 r=0, `div_by_zero`=0.
- **Overflow:** WIDTH=8 signed -128/-1 → q=8'h80, r=0, `div_by_zero`=0, with the same latency as the other cases.
- **Handshake:**
  - `start` pulsed mid-CALC with different operands → ignored; the first result is unchanged.
  - `start` asserted in the `done` cycle → accepted; the second `done` arrives WIDTH+2 cycles later.
- **Reset:** `rst_n`=0 for one edge during CALC → `busy`=0 and all outputs 0 on the next cycle, and no `done` is ever produced for the aborted request.
